// File: rtl/pcpu_mdu_if.sv
// Request/response bundle between the EX stage and the multiply/divide unit.
// start is taken only while the unit can accept; done pulses for one cycle with result valid.
interface pcpu_mdu_if #(parameter int XLEN = 32);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            flush;
  logic            busy;
  logic            stall_req;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, funct3, rs1, rs2, flush,
    input  busy, stall_req, done, result
  );

  modport slave (
    input  start, funct3, rs1, rs2, flush,
    output busy, stall_req, done, result
  );
endinterface

// File: rtl/pcpu_mdu.sv
// Iterative RV32M/RV64M multiply/divide unit: one product or quotient bit per cycle,
// single-cycle handling of divide-by-zero and signed overflow, abortable by flush.
module pcpu_mdu #(
  parameter int XLEN = 32
) (
  input  logic          clk,
  input  logic          reset,
  pcpu_mdu_if.slave     bus,
  output logic [1:0]    state_dbg
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state, state_n;
  logic [CW-1:0]     cnt;
  logic [2:0]        f3;
  logic              s1, s2;
  logic [XLEN-1:0]   a, b, rem, quo, result_q;
  logic [2*XLEN-1:0] prod;

  logic              accept, take;
  logic              sg1, sg2, neg1, neg2;
  logic              div_zero, div_ovf, special;
  logic [XLEN-1:0]   special_res;
  logic [XLEN:0]     shifted;
  logic [XLEN-1:0]   diff;
  logic              ge;
  logic [2*XLEN-1:0] prod_n, prod_s;
  logic [XLEN-1:0]   q_s, r_s, fix_res;

  assign accept    = (state == S_IDLE) || (state == S_DONE);
  assign take      = bus.start && accept && !bus.flush;
  assign state_dbg = state;
  assign bus.result = result_q;

  // Request decode: signedness, sign flags and the single-cycle special cases.
  always_comb begin
    sg1 = 1'b0;
    sg2 = 1'b0;
    case (bus.funct3)
      3'd1, 3'd4, 3'd6: begin sg1 = 1'b1; sg2 = 1'b1; end
      3'd2:             sg1 = 1'b1;
      default:          ;
    endcase
    neg1     = sg1 && bus.rs1[XLEN-1];
    neg2     = sg2 && bus.rs2[XLEN-1];
    div_zero = bus.funct3[2] && (bus.rs2 == '0);
    div_ovf  = ((bus.funct3 == 3'd4) || (bus.funct3 == 3'd6)) &&
               (bus.rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (bus.rs2 == '1);
    special  = div_zero || div_ovf;
    if (div_zero) special_res = bus.funct3[1] ? bus.rs1 : '1;
    else          special_res = bus.funct3[1] ? '0 : bus.rs1;
  end

  // One iteration step; cnt walks the operand bits MSB first.
  always_comb begin
    shifted = {rem, a[cnt]};
    ge      = shifted >= {1'b0, b};
    diff    = shifted[XLEN-1:0] - b;
    prod_n  = {prod[2*XLEN-2:0], 1'b0} + (b[cnt] ? {{XLEN{1'b0}}, a} : '0);
    prod_s  = (s1 ^ s2) ? -prod : prod;
    q_s     = (s1 ^ s2) ? -quo : quo;
    r_s     = s1 ? -rem : rem;
    if (f3[2])          fix_res = f3[1] ? r_s : q_s;
    else if (f3 == 3'd0) fix_res = prod_s[XLEN-1:0];
    else                fix_res = prod_s[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_n       = state;
    bus.busy      = (state == S_CALC) || (state == S_FIX);
    bus.done      = (state == S_DONE);
    bus.stall_req = bus.busy || take;
    if (bus.flush) begin
      state_n = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (take) state_n = special ? S_DONE : S_CALC;
        S_CALC:  if (cnt == '0) state_n = S_FIX;
        S_FIX:   state_n = S_DONE;
        S_DONE:  state_n = take ? (special ? S_DONE : S_CALC) : S_IDLE;
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      f3       <= '0;
      s1       <= 1'b0;
      s2       <= 1'b0;
      a        <= '0;
      b        <= '0;
      rem      <= '0;
      quo      <= '0;
      prod     <= '0;
      result_q <= '0;
    end else begin
      state <= state_n;
      if (take) begin
        f3   <= bus.funct3;
        s1   <= neg1;
        s2   <= neg2;
        a    <= neg1 ? -bus.rs1 : bus.rs1;
        b    <= neg2 ? -bus.rs2 : bus.rs2;
        rem  <= '0;
        quo  <= '0;
        prod <= '0;
        cnt  <= CW'(XLEN - 1);
        if (special) result_q <= special_res;
      end else if (state == S_CALC) begin
        if (cnt != '0) cnt <= cnt - CW'(1);
        if (f3[2]) begin
          rem <= ge ? diff : shifted[XLEN-1:0];
          quo <= {quo[XLEN-2:0], ge};
        end else begin
          prod <= prod_n;
        end
      end else if ((state == S_FIX) && !bus.flush) begin
        result_q <= fix_res;
      end
    end
  end

endmodule
